decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter PC_W, default 32, program-counter width carried alongside the instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input PC_W: upstream handshake plus fetched word and its PC.
REQ-006 SHALL have port flush  input  1  discards all held entries.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-008 SHALL have outputs opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7, imm XLEN, fmt 3, pc PC_W: decoded fields of the head entry.
REQ-009 SHALL have outputs uses_rs1 1, uses_rs2 1, writes_rd 1, illegal 1: per-instruction qualifiers.

Function
REQ-010 SHALL transfer on a clock edge when valid and ready are both 1, independently on each side.
REQ-011 SHALL hold a two-entry buffer (head, skid); an accepted instruction appears on outputs with out_valid=1 one cycle after acceptance (latency 1) when the buffer was empty.
REQ-012 SHALL drive in_ready = NOT skid_valid (registered, no combinational out_ready->in_ready path).
REQ-013 SHALL, with out_valid=1 and out_ready=0, hold every output stable until the head is accepted.
REQ-014 SHALL present entries in strict acceptance order; simultaneous accept-in and accept-out with only the head full moves the new entry directly to head.
REQ-015 SHALL classify fmt: R=0 (0110011), I=1 (0010011, 0000011, 1100111, 1110011, 0001111), S=2 (0100011), B=3 (1100011), U=4 (0110111, 0010111), J=5 (1101111), NONE=7.
REQ-016 SHALL, when XLEN=64, also accept 0011011 as I and 0111011 as R; when XLEN=32 these are illegal.
REQ-017 SHALL produce imm sign-extended from instr[31] to XLEN per RISC-V I/S/B/U/J layouts; R and NONE give imm=0.
REQ-018 SHALL assert illegal when instr[1:0]!=2'b11 or opcode is unlisted; illegal entries still flow through with fmt=NONE and all use/write flags 0.
REQ-019 SHALL drive writes_rd=1 for R, I, U, J except when rd==0; uses_rs1 for R, I, S, B; uses_rs2 for R, S, B.
REQ-020 SHALL, on flush, clear both valid flags next edge, ignore a same-cycle in_valid, and take priority over every handshake.

Reset
REQ-021 SHALL, while reset=1, clear head/skid valid, force out_valid=0, in_ready=1, and all decoded outputs to 0 (fmt=0, pc=0).
REQ-022 SHALL, on reset mid-transfer, drop held entries without emitting them.

Configuration
REQ-023 SHALL, with DECODE_PERF_CNT_EN defined, add outputs decoded_cnt 32 and illegal_cnt 32: saturating counts of head entries accepted downstream (all / illegal), reset to 0, unaffected by flushed entries.
REQ-024 SHALL, without DECODE_PERF_CNT_EN, omit both ports and counter logic entirely.

Structure
REQ-025 SHALL place opcode constants and the fmt enum in shared package decode_pkg.
REQ-026 SHALL implement field/immediate extraction in combinational sub-module decode_fields, instantiated once at the buffer input so stored entries are pre-decoded.

Verification
REQ-027 SHALL test: 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle fmt=1, rd=1, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0.
REQ-028 SHALL test: 0x0021A423 (sw x2,8(x3)) -> fmt=2, rs1=3, rs2=2, imm=8, writes_rd=0.
REQ-029 SHALL test: 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC; with XLEN=64 imm=0xFFFFFFFFFFFFFFFC.
REQ-030 SHALL test: out_ready=0, three back-to-back instrs -> first two accepted, in_ready=0 from the cycle after the second, third held; out_ready=1 drains in order one per cycle.
REQ-031 SHALL test: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged.
REQ-032 SHALL test: 0x00000000 accepted downstream -> illegal=1, fmt=7; with DECODE_PERF_CNT_EN illegal_cnt and decoded_cnt increment by 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction-format enum and opcode-to-format lookup
// for the decode stage.
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // The *W opcodes only exist on RV64; on RV32 they fall through as illegal.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc, input logic rv64);
        fmt_e f;
        case (opc)
            OPC_OP:                       f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM:     f = FMT_I;
            OPC_STORE:                    f = FMT_S;
            OPC_BRANCH:                   f = FMT_B;
            OPC_LUI, OPC_AUIPC:           f = FMT_U;
            OPC_JAL:                      f = FMT_J;
            OPC_OP_IMM_32:                f = rv64 ? FMT_I : FMT_NONE;
            OPC_OP_32:                    f = rv64 ? FMT_R : FMT_NONE;
            default:                      f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational RISC-V field and immediate extraction with format
// classification and register-use qualifiers.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [6:0]      o_opcode,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_uses_rs1,
    output logic            o_uses_rs2,
    output logic            o_writes_rd,
    output logic            o_illegal
);

    fmt_e               w_fmt;
    logic signed [31:0] w_imm32;

    assign o_opcode = i_instr[6:0];
    assign o_rd     = i_instr[11:7];
    assign o_funct3 = i_instr[14:12];
    assign o_rs1    = i_instr[19:15];
    assign o_rs2    = i_instr[24:20];
    assign o_funct7 = i_instr[31:25];

    always_comb begin
        w_fmt = opcode_fmt(i_instr[6:0], XLEN == 64);
        if (i_instr[1:0] != 2'b11) begin
            w_fmt = FMT_NONE;
        end

        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Signed cast carries bit 31 up to XLEN on RV64.
    assign o_imm       = XLEN'(w_imm32);
    assign o_fmt       = w_fmt;
    assign o_illegal   = (w_fmt == FMT_NONE);
    assign o_uses_rs1  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
    assign o_uses_rs2  = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
    assign o_writes_rd = ((w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J))
                         && (i_instr[11:7] != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: two-entry head/skid buffer of pre-decoded instructions with
// flush. Optional perf counters enabled by macro DECODE_PERF_CNT_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [PC_W-1:0] pc,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd,
    output logic            illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     decoded_cnt,
    output logic [31:0]     illegal_cnt
`endif
);

    localparam int ENT_W = 7 + 5 + 5 + 5 + 3 + 7 + XLEN + 3 + PC_W + 4;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_funct3, w_fmt;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm;
    logic            w_uses_rs1, w_uses_rs2, w_writes_rd, w_illegal;
    logic [ENT_W-1:0] w_new;
    logic [ENT_W-1:0] r_head, r_skid;
    logic            r_head_vld, r_skid_vld;
    logic            w_acc_in, w_acc_out;

    decode_fields #(.XLEN(XLEN)) u_fields (
        .i_instr     (in_instr),
        .o_opcode    (w_opcode),
        .o_rd        (w_rd),
        .o_rs1       (w_rs1),
        .o_rs2       (w_rs2),
        .o_funct3    (w_funct3),
        .o_funct7    (w_funct7),
        .o_imm       (w_imm),
        .o_fmt       (w_fmt),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_writes_rd (w_writes_rd),
        .o_illegal   (w_illegal)
    );

    assign w_new = {w_opcode, w_rd, w_rs1, w_rs2, w_funct3, w_funct7, w_imm, w_fmt,
                    in_pc, w_uses_rs1, w_uses_rs2, w_writes_rd, w_illegal};
    assign {opcode, rd, rs1, rs2, funct3, funct7, imm, fmt,
            pc, uses_rs1, uses_rs2, writes_rd, illegal} = r_head;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = ~r_skid_vld;
    assign out_valid = r_head_vld;
    assign w_acc_in  = in_valid & ~r_skid_vld & ~flush;
    assign w_acc_out = r_head_vld & out_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            if (w_acc_out) r_skid_vld <= 1'b0;
        end else if (r_head_vld) begin
            if (w_acc_in && !w_acc_out)      r_skid_vld <= 1'b1;
            else if (!w_acc_in && w_acc_out) r_head_vld <= 1'b0;
        end else if (w_acc_in) begin
            r_head_vld <= 1'b1;
        end
    end

    // Head refills from skid first so ordering is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_acc_out && r_skid_vld)
                r_head <= r_skid;
            else if (w_acc_in && (!r_head_vld || w_acc_out))
                r_head <= w_new;
            if (w_acc_in && r_head_vld && !w_acc_out)
                r_skid <= w_new;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_decoded_cnt, r_illegal_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decoded_cnt <= '0;
            r_illegal_cnt <= '0;
        end else if (w_acc_out) begin
            if (r_decoded_cnt != '1)          r_decoded_cnt <= r_decoded_cnt + 32'd1;
            if (illegal && r_illegal_cnt != '1) r_illegal_cnt <= r_illegal_cnt + 32'd1;
        end
    end

    assign decoded_cnt = r_decoded_cnt;
    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors with literal expectations plus a
// queue-based reference model compared on every falling edge.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc, pc;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3, fmt;
    logic [XLEN-1:0] imm;
    logic            uses_rs1, uses_rs2, writes_rd, illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]     decoded_cnt, illegal_cnt;
    logic [31:0]     save_dec, save_ill;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .fmt(fmt), .pc(pc),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd), .illegal(illegal)
`ifdef DECODE_PERF_CNT_EN
        , .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode built from the ISA rules: format by opcode, immediate
    // as a signed integer value, then truncated to XLEN.
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] f,
                                       output logic [63:0] im, output logic u1,
                                       output logic u2, output logic wr, output logic il);
        longint v;
        f = 3'd7;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'h33:                         f = 3'd0;
                7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 3'd1;
                7'h23:                         f = 3'd2;
                7'h63:                         f = 3'd3;
                7'h37, 7'h17:                  f = 3'd4;
                7'h6F:                         f = 3'd5;
                7'h1B:                         f = (XLEN == 64) ? 3'd1 : 3'd7;
                7'h3B:                         f = (XLEN == 64) ? 3'd0 : 3'd7;
                default:                       f = 3'd7;
            endcase
        end
        case (f)
            3'd1: v = longint'($signed(ins[31:20]));
            3'd2: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd3: v = 2 * longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]}));
            3'd4: v = longint'($signed(ins[31:12])) * 4096;
            3'd5: v = 2 * longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]}));
            default: v = 0;
        endcase
        im = 64'(v);
        if (XLEN == 32) im = im & 64'hFFFF_FFFF;
        u1 = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd3);
        u2 = (f == 3'd0) || (f == 3'd2) || (f == 3'd3);
        wr = ((f == 3'd0) || (f == 3'd1) || (f == 3'd4) || (f == 3'd5)) && (ins[11:7] != 5'd0);
        il = (f == 3'd7);
    endfunction

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_dec_cnt, m_ill_cnt;
    int          m_sz;
    bit          m_pop, m_push;
    logic [2:0]  e_fmt;
    logic [63:0] e_imm;
    logic        e_u1, e_u2, e_wr, e_il;

    // Reference model: FIFO of at most two accepted instructions.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_dec_cnt = 0;
            m_ill_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            m_sz   = q.size();
            m_pop  = out_ready && (m_sz > 0);
            m_push = in_valid && (m_sz < 2);
            if (m_pop) begin
                ref_decode(q[0].instr, e_fmt, e_imm, e_u1, e_u2, e_wr, e_il);
                if (m_dec_cnt != 32'hFFFF_FFFF) m_dec_cnt = m_dec_cnt + 1;
                if (e_il && m_ill_cnt != 32'hFFFF_FFFF) m_ill_cnt = m_ill_cnt + 1;
                void'(q.pop_front());
            end
            if (m_push) q.push_back('{in_instr, in_pc});
        end
    end

    logic [2:0]  c_fmt;
    logic [63:0] c_imm;
    logic        c_u1, c_u2, c_wr, c_il;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst out_valid", 64'(out_valid), 64'd0);
            chk("rst in_ready",  64'(in_ready),  64'd1);
            chk("rst fmt",       64'(fmt),       64'd0);
            chk("rst pc",        64'(pc),        64'd0);
            chk("rst imm",       64'(imm),       64'd0);
        end else begin
            chk("m out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("m in_ready",  64'(in_ready),  64'(q.size() < 2));
            if (q.size() > 0) begin
                ref_decode(q[0].instr, c_fmt, c_imm, c_u1, c_u2, c_wr, c_il);
                chk("m opcode",    64'(opcode),    64'(q[0].instr[6:0]));
                chk("m rd",        64'(rd),        64'(q[0].instr[11:7]));
                chk("m rs1",       64'(rs1),       64'(q[0].instr[19:15]));
                chk("m rs2",       64'(rs2),       64'(q[0].instr[24:20]));
                chk("m funct3",    64'(funct3),    64'(q[0].instr[14:12]));
                chk("m funct7",    64'(funct7),    64'(q[0].instr[31:25]));
                chk("m imm",       64'(imm),       c_imm);
                chk("m fmt",       64'(fmt),       64'(c_fmt));
                chk("m pc",        64'(pc),        64'(q[0].pc));
                chk("m uses_rs1",  64'(uses_rs1),  64'(c_u1));
                chk("m uses_rs2",  64'(uses_rs2),  64'(c_u2));
                chk("m writes_rd", 64'(writes_rd), 64'(c_wr));
                chk("m illegal",   64'(illegal),   64'(c_il));
            end
`ifdef DECODE_PERF_CNT_EN
            chk("m decoded_cnt", 64'(decoded_cnt), 64'(m_dec_cnt));
            chk("m illegal_cnt", 64'(illegal_cnt), 64'(m_ill_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [31:0] ins, input logic [PC_W-1:0] p);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = p;
        tick();
        in_valid = 1'b0;
    endtask

    localparam int NSTREAM = 8;
    logic [31:0] stream [NSTREAM] = '{32'h002081B3, 32'h123450B7, 32'h008000EF, 32'h00000013,
                                      32'hFFF00092, 32'h0000051B, 32'h00B50503, 32'hFE209AE3};
    logic [NSTREAM-1:0] ordy_pat = 8'b0110_1001;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk("lit rst out_valid", 64'(out_valid), 64'd0);
        chk("lit rst in_ready",  64'(in_ready),  64'd1);
        chk("lit rst rd",        64'(rd),        64'd0);
        reset = 1'b0;
        tick();

        // addi x1,x0,-1
        out_ready = 1'b1;
        send1(32'hFFF00093, 32'h100);
        chk("addi out_valid", 64'(out_valid), 64'd1);
        chk("addi fmt",       64'(fmt),       64'd1);
        chk("addi rd",        64'(rd),        64'd1);
        chk("addi imm",       64'(imm),       64'hFFFF_FFFF);
        chk("addi writes_rd", 64'(writes_rd), 64'd1);
        chk("addi uses_rs2",  64'(uses_rs2),  64'd0);
        tick();
        chk("addi drained",   64'(out_valid), 64'd0);

        // sw x2,8(x3)
        send1(32'h0021A423, 32'h104);
        chk("sw fmt",       64'(fmt),       64'd2);
        chk("sw rs1",       64'(rs1),       64'd3);
        chk("sw rs2",       64'(rs2),       64'd2);
        chk("sw imm",       64'(imm),       64'd8);
        chk("sw writes_rd", 64'(writes_rd), 64'd0);
        tick();

        // beq x0,x0,-4
        send1(32'hFE000EE3, 32'h108);
        chk("beq fmt", 64'(fmt), 64'd3);
        chk("beq imm", 64'(imm), 64'hFFFF_FFFC);
        tick();

        // Mixed stream with irregular downstream back-pressure.
        for (int i = 0; i < NSTREAM; i++) begin
            int  w;
            bit  acc;
            in_valid  = 1'b1;
            in_instr  = stream[i];
            in_pc     = 32'h400 + 32'(4 * i);
            w = 0;
            acc = 1'b0;
            do begin
                out_ready = ordy_pat[(i + w) % NSTREAM];
                acc = in_ready;
                tick();
                w++;
            end while (!acc && w < 20);
            if (!acc) chk("stream accept timeout", 64'd0, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("stream drained", 64'(out_valid), 64'd0);

        // Back-pressure: two taken, third held, then in-order drain.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        tick();
        chk("bp in_ready after 1st", 64'(in_ready), 64'd1);
        in_instr = 32'h00200113; in_pc = 32'h204;
        tick();
        chk("bp in_ready after 2nd", 64'(in_ready), 64'd0);
        in_instr = 32'h00300193; in_pc = 32'h208;
        tick();
        chk("bp in_ready held", 64'(in_ready), 64'd0);
        chk("bp head pc",       64'(pc),       64'h200);
        tick();
        chk("bp head stable",   64'(pc),       64'h200);
        chk("bp head rd",       64'(rd),       64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp drain 2nd pc",  64'(pc),       64'h204);
        chk("bp in_ready free", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp drain 3rd pc",  64'(pc),       64'h208);
        tick();
        chk("bp empty",         64'(out_valid), 64'd0);

        // Flush with both entries full and a colliding in_valid.
        out_ready = 1'b0;
        send1(32'h00400213, 32'h300);
        send1(32'h00500293, 32'h304);
`ifdef DECODE_PERF_CNT_EN
        save_dec = decoded_cnt;
        save_ill = illegal_cnt;
`endif
        in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h308;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush in_ready",  64'(in_ready),  64'd1);
`ifdef DECODE_PERF_CNT_EN
        chk("flush decoded_cnt", 64'(decoded_cnt), 64'(save_dec));
        chk("flush illegal_cnt", 64'(illegal_cnt), 64'(save_ill));
`endif
        tick();
        chk("flush dropped in", 64'(out_valid), 64'd0);

        // All-zero word is illegal.
        out_ready = 1'b1;
`ifdef DECODE_PERF_CNT_EN
        save_dec = decoded_cnt;
        save_ill = illegal_cnt;
`endif
        send1(32'h00000000, 32'h500);
        chk("zero illegal",   64'(illegal),   64'd1);
        chk("zero fmt",       64'(fmt),       64'd7);
        chk("zero writes_rd", 64'(writes_rd), 64'd0);
        tick();
`ifdef DECODE_PERF_CNT_EN
        chk("zero decoded_cnt", 64'(decoded_cnt), 64'(save_dec + 32'd1));
        chk("zero illegal_cnt", 64'(illegal_cnt), 64'(save_ill + 32'd1));
`endif

        // Reset while entries are held drops them.
        out_ready = 1'b0;
        send1(32'h00700393, 32'h600);
        send1(32'h00800413, 32'h604);
        reset = 1'b1;
        tick();
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("midrst nothing emitted", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
